// File: rtl/common_skid_buffer_registered_pkg.sv
// Shared definitions for the registered two-entry skid buffer.
package common_skid_buffer_registered_pkg;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] HALF  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

endpackage

// File: rtl/common_skid_buffer_registered_stdmacro.sv
// Storage primitives: plain and enabled D flops, async active-high reset to zero.
module stdmacro_dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) q_o <= '0;
        else       q_o <= d_i;
    end
endmodule

module stdmacro_dffe #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     q_o <= '0;
        else if (en_i) q_o <= d_i;
    end
endmodule

// File: rtl/common_skid_buffer_registered.sv
// Two-entry skid buffer with every output taken straight from a flop,
// so upstream and downstream handshakes are fully decoupled in timing.
module common_skid_buffer_registered
    import common_skid_buffer_registered_pkg::*;
#(
    parameter int BUFFER_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BUFFER_WIDTH-1:0] prev_i_data,
    input  logic                    prev_i_valid,
    output logic                    prev_o_ready,
    output logic [BUFFER_WIDTH-1:0] next_o_data,
    output logic                    next_o_valid,
    input  logic                    next_i_ready
);

    logic [1:0]              state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    valid_q, valid_d;
    logic [BUFFER_WIDTH-1:0] out_q, out_d, skid_q;
    logic                    out_en, skid_en;
    logic                    up_xfer, dn_xfer;

    assign up_xfer = prev_i_valid & ready_q;
    assign dn_xfer = next_i_ready & valid_q;

    // State register
    stdmacro_dff #(.WIDTH(2)) u_state (
        .clk_i(clk), .rst_i(reset), .d_i(state_d), .q_o(state_q)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (up_xfer) state_d = HALF;
            HALF: begin
                if (up_xfer && !dn_xfer)      state_d = FULL;
                else if (!up_xfer && dn_xfer) state_d = EMPTY;
            end
            FULL:    if (dn_xfer) state_d = HALF;
            default: state_d = EMPTY;
        endcase
    end

    // Datapath controls; SKID only ever captures when OUT is occupied and stalled
    always_comb begin
        out_en  = 1'b0;
        out_d   = prev_i_data;
        skid_en = 1'b0;
        case (state_q)
            EMPTY: out_en = up_xfer;
            HALF: begin
                out_en  = up_xfer & dn_xfer;
                skid_en = up_xfer & ~dn_xfer;
            end
            FULL: begin
                out_en = dn_xfer;
                out_d  = skid_q;
            end
            default: ;
        endcase
    end

    // Handshake flags are registered copies of the next state's occupancy
    assign ready_d = (state_d != FULL);
    assign valid_d = (state_d != EMPTY);

    stdmacro_dff #(.WIDTH(1)) u_ready (
        .clk_i(clk), .rst_i(reset), .d_i(ready_d), .q_o(ready_q)
    );

    stdmacro_dff #(.WIDTH(1)) u_valid (
        .clk_i(clk), .rst_i(reset), .d_i(valid_d), .q_o(valid_q)
    );

    stdmacro_dffe #(.WIDTH(BUFFER_WIDTH)) u_out (
        .clk_i(clk), .rst_i(reset), .en_i(out_en), .d_i(out_d), .q_o(out_q)
    );

    stdmacro_dffe #(.WIDTH(BUFFER_WIDTH)) u_skid (
        .clk_i(clk), .rst_i(reset), .en_i(skid_en), .d_i(prev_i_data), .q_o(skid_q)
    );

    assign prev_o_ready = ready_q;
    assign next_o_valid = valid_q;
    assign next_o_data  = out_q;

endmodule

// File: tb/tb_common_skid_buffer_registered.sv
// Bench for the registered skid buffer: directed vector table, streaming,
// randomized traffic against a queue model, and reset while full.
module tb_common_skid_buffer_registered;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] prev_i_data;
    logic         prev_i_valid;
    logic         prev_o_ready;
    logic [W-1:0] next_o_data;
    logic         next_o_valid;
    logic         next_i_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    common_skid_buffer_registered #(.BUFFER_WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .prev_i_data  (prev_i_data),
        .prev_i_valid (prev_i_valid),
        .prev_o_ready (prev_o_ready),
        .next_o_data  (next_o_data),
        .next_o_valid (next_o_valid),
        .next_i_ready (next_i_ready)
    );

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic         ev;
        logic [W-1:0] ed;
        logic         erdy;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs at the falling edge, then sample just after the rising edge
    task automatic step(input logic v, input logic [W-1:0] d, input logic r);
        @(negedge clk);
        prev_i_valid = v;
        prev_i_data  = d;
        next_i_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] q[$];
        logic         mrdy;
        logic         up, dn;
        logic         pre_valid;
        logic [W-1:0] pre_data;
        logic         v, r;
        logic [W-1:0] d;

        //           v  d      r  ev ed     erdy
        tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[1]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1};
        tbl[3]  = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1};
        tbl[4]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0};
        tbl[5]  = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b0};
        tbl[6]  = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 1'b1};
        tbl[7]  = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 1'b1};
        tbl[9]  = '{1'b1, 8'h44, 1'b0, 1'b1, 8'h44, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 1'b1};
        tbl[11] = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'h44, 1'b1};
        tbl[12] = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h55, 1'b1};
        tbl[13] = '{1'b1, 8'h66, 1'b0, 1'b1, 8'h55, 1'b0};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b0};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h66, 1'b1};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h66, 1'b1};

        reset        = 1'b1;
        prev_i_valid = 1'b0;
        prev_i_data  = '0;
        next_i_ready = 1'b0;
        #1;
        check("reset_valid", 32'(next_o_valid), 32'd0);
        check("reset_ready", 32'(prev_o_ready), 32'd0);
        check("reset_data",  32'(next_o_data),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_ready", 32'(prev_o_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table: single beat, stall fill, drain, hold, idle data ignored
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r);
            check($sformatf("tbl%0d_valid", i), 32'(next_o_valid), 32'(tbl[i].ev));
            check($sformatf("tbl%0d_data", i),  32'(next_o_data),  32'(tbl[i].ed));
            check($sformatf("tbl%0d_ready", i), 32'(prev_o_ready), 32'(tbl[i].erdy));
        end

        // Streaming: one beat per cycle, never full
        for (int i = 0; i < 256; i++) begin
            step(1'b1, W'(i), 1'b1);
            check($sformatf("stream%0d_valid", i), 32'(next_o_valid), 32'd1);
            check($sformatf("stream%0d_data", i),  32'(next_o_data),  32'(i));
            check($sformatf("stream%0d_ready", i), 32'(prev_o_ready), 32'd1);
        end
        step(1'b0, 8'h00, 1'b1);
        check("stream_end_valid", 32'(next_o_valid), 32'd0);

        // Random traffic against a two-deep FIFO model
        q.delete();
        mrdy = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            pre_valid = next_o_valid;
            pre_data  = next_o_data;
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = W'($urandom);
            prev_i_valid = v;
            prev_i_data  = d;
            next_i_ready = r;
            @(posedge clk);
            up = v & mrdy;
            dn = r & (q.size() > 0);
            if (dn) void'(q.pop_front());
            if (up) q.push_back(d);
            mrdy = (q.size() < 2);
            #1;
            check("rand_valid", 32'(next_o_valid), 32'(q.size() > 0));
            check("rand_ready", 32'(prev_o_ready), 32'(mrdy));
            if (q.size() > 0) check("rand_data", 32'(next_o_data), 32'(q[0]));
            if (pre_valid && !r) begin
                check("stall_valid", 32'(next_o_valid), 32'd1);
                check("stall_data",  32'(next_o_data),  32'(pre_data));
            end
        end

        // Reset while full: outputs drop immediately, nothing stale afterwards
        repeat (3) step(1'b0, 8'h00, 1'b1);
        check("pre_fill_valid", 32'(next_o_valid), 32'd0);
        step(1'b1, 8'h77, 1'b0);
        step(1'b1, 8'h88, 1'b0);
        check("full_ready", 32'(prev_o_ready), 32'd0);
        check("full_valid", 32'(next_o_valid), 32'd1);
        check("full_data",  32'(next_o_data),  32'h77);
        @(negedge clk);
        prev_i_valid = 1'b0;
        next_i_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(next_o_valid), 32'd0);
        check("async_rst_ready", 32'(prev_o_ready), 32'd0);
        check("async_rst_data",  32'(next_o_data),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 8'h00, 1'b1);
        check("post_rst_ready", 32'(prev_o_ready), 32'd1);
        check("post_rst_valid", 32'(next_o_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        check("post_rst_valid2", 32'(next_o_valid), 32'd0);
        step(1'b1, 8'h99, 1'b1);
        check("post_rst_beat_valid", 32'(next_o_valid), 32'd1);
        check("post_rst_beat_data",  32'(next_o_data),  32'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/common_skid_buffer_registered.md
COMMON_SKID_BUFFER_REGISTERED -- requirements
Module: common_skid_buffer_registered

Interface
REQ-001 SHALL have parameter: BUFFER_WIDTH, default 1, payload width in bits.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: prev_i_data  input  BUFFER_WIDTH  upstream payload.
REQ-005 SHALL have port: prev_i_valid  input  1  upstream payload valid.
REQ-006 SHALL have port: prev_o_ready  output  1  buffer can accept, driven directly from a flop.
REQ-007 SHALL have port: next_o_data  output  BUFFER_WIDTH  downstream payload, driven directly from a flop.
REQ-008 SHALL have port: next_o_valid  output  1  downstream payload valid, driven directly from a flop.
REQ-009 SHALL have port: next_i_ready  input  1  downstream can accept.

Function
REQ-010 SHALL count a transfer on a side only at a rising clk edge where that side's valid and ready are both 1.
REQ-011 SHALL hold two entries: the output register (OUT) and the skid register (SKID).
REQ-012 SHALL implement states EMPTY (0 entries), HALF (OUT valid), FULL (OUT and SKID valid).
REQ-013 EMPTY: on an upstream transfer, load OUT from prev_i_data and go to HALF; otherwise stay in EMPTY.
REQ-014 HALF, upstream and downstream transfer together: load OUT with new data and stay in HALF.
REQ-015 HALF, upstream transfer only: load SKID and go to FULL; OUT is unchanged.
REQ-016 HALF, downstream transfer only: go to EMPTY.
REQ-017 HALF, no transfer: hold.
REQ-018 FULL, downstream transfer: copy SKID into OUT and go to HALF; otherwise hold.
REQ-019 FULL: no upstream transfer is possible, because prev_o_ready is 0.
REQ-020 next_o_valid SHALL be 1 exactly in HALF and FULL.
REQ-021 prev_o_ready SHALL be a flop loaded each edge with (next state != FULL).
REQ-022 Latency SHALL be 1 cycle from upstream transfer to next_o_valid=1 with that data when the buffer was EMPTY.
REQ-023 Sustained throughput SHALL be 1 transfer per cycle while next_i_ready=1.
REQ-024 Order SHALL be preserved, with no loss or duplication.
REQ-025 next_o_data SHALL stay stable while next_o_valid=1 and next_i_ready=0.
REQ-026 Upstream SHALL be allowed to drop prev_i_valid at any time; when prev_i_valid=0, prev_i_data SHALL be ignored.
REQ-027 The block SHALL tolerate a downstream next_i_ready that toggles every cycle or lags by one beat, without loss.
REQ-028 No combinational path SHALL exist from any input to any output.

Reset
REQ-029 reset=1 SHALL asynchronously force state=EMPTY, next_o_valid=0, prev_o_ready=0, and OUT=SKID=0.
REQ-030 prev_o_ready SHALL become 1 at the first rising clk edge after reset deasserts.
REQ-031 Reset mid-operation SHALL discard both entries with no partial transfer afterwards.

Structure
REQ-032 State encodings (EMPTY=2'd0, HALF=2'd1, FULL=2'd2) SHALL be localparams in the shared common buffer definitions header.
REQ-033 All storage SHALL use the stdmacro_dff / stdmacro_dffe primitives: OUT and SKID as dffe, state and ready as dff.
REQ-034 The block SHALL have no sub-module other than those primitives, and the next-state logic SHALL be in this module.
REQ-035 The block SHALL be synthesizable for BUFFER_WIDTH from 1 to 512.

Verification
REQ-036 Single beat (BUFFER_WIDTH=8): after reset, prev_i_valid=1 with data 0xA5 for 1 cycle, next_i_ready=1 -> next_o_valid=1 with data 0xA5 exactly 1 cycle later, then 0.
REQ-037 Stall fill: next_i_ready=0, push 0x11 and 0x22 -> prev_o_ready=0 after the second transfer, next_o_data=0x11 stable; the third beat 0x33 is held upstream.
REQ-038 Drain: from REQ-037, set next_i_ready=1 -> outputs 0x11, 0x22, 0x33 on consecutive cycles; prev_o_ready returns to 1 one cycle after the first drain.
REQ-039 Streaming: 256 beats 0x00..0xFF with both sides always ready -> 256 consecutive outputs in order, and state never reaches FULL.
REQ-040 Random: random prev_i_valid and next_i_ready at 50% for 10000 cycles -> scoreboard exact in-order match, and a protocol checker confirms data is stable under stall.
REQ-041 Reset in FULL: assert reset asynchronously -> next_o_valid=0 and prev_o_ready=0 immediately, with no stale beat after release.
